// File: rtl/instr_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer.
//   - MIPS-style opcode/funct constants used by control-flow predecode
//   - default NOP and HALT encodings
//   - FSM state type ibuf_state_t
//   - is_ctrl(): predecode helper (J/JAL/BEQ/BNE/JR)
package instr_fetch_buffer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] FN_JR    = 6'd8;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0020;
  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2
  } ibuf_state_t;

  // True for instructions that redirect the pc. Callers pass the opcode
  // (top 6 bits) and funct (low 6 bits) so the helper is width-agnostic.
  function automatic logic is_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
    logic r;
    r = 1'b0;
    case (opcode)
      OP_J, OP_JAL, OP_BEQ, OP_BNE: r = 1'b1;
      OP_RTYPE:                     r = (funct == FN_JR);
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fetch_buffer_fifo.sv
// ibuf_fifo: circular storage for the fetch buffer.
//   clk, rst_      clock, asynchronous active-low reset (pointers/count only)
//   push, wr_data  write an entry at the tail (ignored when full or clearing)
//   pop            retire the head entry (ignored when empty or clearing)
//   clear          drop all contents; wins over push and pop
//   rd_data        head entry (combinational read, undefined when empty)
//   count          occupied entries; full/empty derived from it
// The storage array itself is deliberately not reset.
module ibuf_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [W-1:0]                   wr_data,
  output logic [W-1:0]                   rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);
  import instr_fetch_buffer_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is plain AW-bit overflow.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: instruction queue between instruction memory and decode.
//   clk, rst_          clock, asynchronous active-low reset
//   in_valid/in_ready  fetch-side handshake; in_instr/in_pc are the beat
//   flush              redirect: drop contents, then squash FLUSH_LAT cycles of fetch
//   hold               decode stall; head is not popped
//   out_valid          head entry valid; out_instr/out_pc/out_ctrl describe it
//                      (NOP_INSTR / 0 / 0 when not valid)
//   halted             a HALT was popped; buffer frozen until flush or reset
//   count              occupied entries
//   state_dbg          current FSM state
//
// Handshake rule (both sides): a beat transfers on a rising edge where
// valid and ready are both high. in_ready depends only on registered state,
// and a pop happens on any edge where out_valid is high and hold is low.
module instr_fetch_buffer #(
  parameter int          BITS       = 32,
  parameter int          PC_BITS    = 32,
  parameter int          DEPTH      = 4,
  parameter int          FLUSH_LAT  = 2,
  parameter logic [31:0] NOP_INSTR  = instr_fetch_buffer_pkg::NOP_INSTR,
  parameter logic [31:0] HALT_INSTR = instr_fetch_buffer_pkg::HALT_INSTR
) (
  input  logic                                clk,
  input  logic                                rst_,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BITS-1:0]                     in_instr,
  input  logic [PC_BITS-1:0]                  in_pc,
  input  logic                                flush,
  input  logic                                hold,
  output logic                                out_valid,
  output logic [BITS-1:0]                     out_instr,
  output logic [PC_BITS-1:0]                  out_pc,
  output logic                                out_ctrl,
  output logic                                halted,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output instr_fetch_buffer_pkg::ibuf_state_t state_dbg
);
  import instr_fetch_buffer_pkg::*;

  localparam int W = PC_BITS + BITS;

  ibuf_state_t       state;
  logic [3:0]        squash_cnt;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [W-1:0]      head;
  logic [BITS-1:0]   head_instr;
  logic [PC_BITS-1:0] head_pc;

  assign head_pc    = head[W-1 -: PC_BITS];
  assign head_instr = head[BITS-1:0];

  // During SQUASH fetch data is accepted so the memory side drains, but
  // nothing is written. Flush overrides any push or pop in its cycle.
  assign in_ready  = ((state == ST_RUN) && !full) || (state == ST_SQUASH);
  assign out_valid = (state == ST_RUN) && !empty;
  assign push      = in_valid && in_ready && (state == ST_RUN) && !flush;
  assign pop       = out_valid && !hold && !flush;

  assign out_instr = out_valid ? head_instr : BITS'(NOP_INSTR);
  assign out_pc    = out_valid ? head_pc : '0;
  assign out_ctrl  = out_valid && is_ctrl(head_instr[BITS-1 -: 6], head_instr[5:0]);
  assign halted    = (state == ST_HALTED);
  assign state_dbg = state;

  ibuf_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .push    (push),
    .pop     (pop),
    .clear   (flush),
    .wr_data ({in_pc, in_instr}),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Control FSM. squash_cnt counts down every SQUASH cycle regardless of
  // fetch traffic; the cycle it reads 1 is the last squashed one.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= ST_RUN;
      squash_cnt <= '0;
    end else if (flush) begin
      if (FLUSH_LAT > 0) begin
        state      <= ST_SQUASH;
        squash_cnt <= 4'(FLUSH_LAT);
      end else begin
        state      <= ST_RUN;
        squash_cnt <= '0;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (pop && (head_instr == BITS'(HALT_INSTR))) state <= ST_HALTED;
        end
        ST_SQUASH: begin
          if (squash_cnt <= 4'd1) begin
            state      <= ST_RUN;
            squash_cnt <= '0;
          end else begin
            squash_cnt <= squash_cnt - 4'd1;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default: begin
          state      <= ST_RUN;
          squash_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer (BITS=PC_BITS=32, DEPTH=4, FLUSH_LAT=2).
module tb_instr_fetch_buffer;
  import instr_fetch_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [31:0] ADD_I = 32'h0022_1820;
  localparam logic [31:0] BEQ_I = 32'h1000_0003;
  localparam logic [31:0] JR_I  = 32'h03E0_0008;

  logic          clk;
  logic          rst_;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc;
  logic          flush;
  logic          hold;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          out_ctrl;
  logic          halted;
  logic [CW-1:0] count;
  ibuf_state_t   state_dbg;

  int tests = 0;
  int fails = 0;

  // Expected {pc, instr} of every beat the bench expects decode to receive.
  logic [63:0] exp_q[$];

  instr_fetch_buffer #(
    .BITS      (32),
    .PC_BITS   (32),
    .DEPTH     (DEPTH),
    .FLUSH_LAT (2)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .hold      (hold),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ctrl  (out_ctrl),
    .halted    (halted),
    .count     (count),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: a pop happens on the coming edge whenever the head is valid
  // and neither hold nor flush block it.
  always @(negedge clk) begin
    if (rst_ && out_valid && !hold && !flush) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mon_unexpected: got pc=%h instr=%h, required no output", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e)
          begin
            fails++;
            $display("FAIL mon_data: got pc=%h instr=%h, required pc=%h instr=%h",
                     out_pc, out_instr, e[63:32], e[31:0]);
          end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] pc, input logic [31:0] instr, input logic keep);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    if (keep) exp_q.push_back({pc, instr});
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_pc    = '0;
    in_instr = '0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    rst_ = 1'b1; hold = 1'b0; flush = 1'b0;
    idle_in();
    #1 rst_ = 1'b0;
    #2;
    // Reset values
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'(NOP_INSTR));
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    check("rst_halted",    64'(halted),    64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_count",     64'(count),     64'd0);
    @(negedge clk);
    rst_ = 1'b1;
    tick();

    // Fill with hold, then drain
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(32'(4 * i), ADD_I + 32'(i << 11), 1'b1);
      tick();
    end
    set_beat(32'h10, ADD_I + 32'h1000, 1'b1);
    tick();
    check("full_count",    64'(count),    64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_pc",   64'(out_pc),   64'd0);
    hold = 1'b0;
    tick();
    check("drain1_count",    64'(count),    64'd3);
    check("drain1_in_ready", 64'(in_ready), 64'd1);
    check("drain1_out_pc",   64'(out_pc),   64'h4);
    tick();
    idle_in();
    check("drain2_count",  64'(count),  64'd3);
    check("drain2_out_pc", 64'(out_pc), 64'h8);
    tick();
    tick();
    check("drain4_out_pc", 64'(out_pc), 64'h10);
    tick();
    check("drain_empty", 64'(out_valid), 64'd0);

    // Flush with three follow-on beats; FLUSH_LAT=2 drops the first two
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(32'h20 + 32'(4 * i), ADD_I, 1'b0);
      tick();
    end
    idle_in();
    check("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sq_count",     64'(count),     64'd0);
    check("sq_out_valid", 64'(out_valid), 64'd0);
    check("sq_in_ready",  64'(in_ready),  64'd1);
    check("sq_state",     64'(state_dbg), 64'(ST_SQUASH));
    set_beat(32'h30, ADD_I, 1'b0);
    tick();
    check("sq2_in_ready", 64'(in_ready), 64'd1);
    set_beat(32'h34, ADD_I, 1'b0);
    tick();
    set_beat(32'h38, ADD_I + 32'h800, 1'b1);
    tick();
    idle_in();
    check("post_sq_count",  64'(count),  64'd1);
    check("post_sq_out_pc", 64'(out_pc), 64'h38);
    hold = 1'b0;
    tick();

    // Predecode, and no bypass when empty
    hold = 1'b1;
    set_beat(32'h40, BEQ_I, 1'b1);
    check("nobypass_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_out_pc",  64'(out_pc),   64'h40);
    check("beq_ctrl",    64'(out_ctrl), 64'd1);
    set_beat(32'h44, JR_I, 1'b1);
    tick();
    set_beat(32'h48, ADD_I, 1'b1);
    tick();
    idle_in();
    hold = 1'b0;
    tick();
    hold = 1'b1;
    check("jr_out_pc", 64'(out_pc),   64'h44);
    check("jr_ctrl",   64'(out_ctrl), 64'd1);
    hold = 1'b0;
    tick();
    hold = 1'b1;
    check("add_instr", 64'(out_instr), 64'(ADD_I));
    check("add_ctrl",  64'(out_ctrl),  64'd0);
    hold = 1'b0;
    tick();
    check("empty_ctrl",  64'(out_ctrl),  64'd0);
    check("empty_instr", 64'(out_instr), 64'(NOP_INSTR));

    // HALT capture and release by flush
    hold = 1'b1;
    set_beat(32'h50, HALT_INSTR, 1'b1);
    tick();
    set_beat(32'h54, ADD_I, 1'b0);
    tick();
    idle_in();
    hold = 1'b0;
    tick();
    check("halt_halted",    64'(halted),    64'd1);
    check("halt_out_valid", 64'(out_valid), 64'd0);
    check("halt_out_instr", 64'(out_instr), 64'(NOP_INSTR));
    check("halt_in_ready",  64'(in_ready),  64'd0);
    check("halt_count",     64'(count),     64'd1);
    set_beat(32'h58, ADD_I, 1'b0);
    tick();
    idle_in();
    check("halt_frozen_count", 64'(count), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("unhalt_halted", 64'(halted), 64'd0);
    check("unhalt_count",  64'(count),  64'd0);
    tick();
    tick();
    check("unhalt_state", 64'(state_dbg), 64'(ST_RUN));

    // Streaming across pointer wrap
    hold = 1'b0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_beat(32'h100 + 32'(4 * i), 32'h0100_0020 + 32'(i << 11), 1'b1);
      tick();
      if (i > 0) check("stream_count", 64'(count), 64'd1);
    end
    idle_in();
    tick();
    check("stream_end_count", 64'(count), 64'd0);

    // Reset asserted mid-stream
    for (int i = 0; i < 3; i++) begin
      set_beat(32'h200 + 32'(4 * i), ADD_I, 1'b1);
      tick();
    end
    rst_ = 1'b0;
    idle_in();
    #1;
    exp_q.delete();
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_instr", 64'(out_instr), 64'(NOP_INSTR));
    check("mrst_out_pc",    64'(out_pc),    64'd0);
    check("mrst_out_ctrl",  64'(out_ctrl),  64'd0);
    check("mrst_halted",    64'(halted),    64'd0);
    check("mrst_in_ready",  64'(in_ready),  64'd1);
    check("mrst_count",     64'(count),     64'd0);
    @(negedge clk);
    rst_ = 1'b1;
    tick();
    tick();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
